// File: rtl/clk_div_pwm.sv
// Programmable clock divider / PWM: clk_out is high for H of every P core cycles, config swaps only at period wrap.
// Latency: enable sampled high in IDLE starts the first period on that same edge (tick + first high cycle registered).
// Backpressure: none; load is a fire-and-forget strobe, bad requests (P < 2) are dropped and flagged on cfg_err.
//
// Ports:
//   clock, reset       - rising-edge clock, asynchronous active-high reset
//   enable             - level run request; dropping it lets the current period finish
//   load               - one-cycle strobe capturing period_in / high_in into the pending slot
//   period_in, high_in - requested period P and high time H, in clock cycles
//   clk_out            - registered divided clock
//   tick               - one-cycle pulse on the first cycle of each output period
//   running            - state is RUN or DRAIN
//   cfg_err            - one-cycle pulse the cycle after a rejected load
module clk_div_pwm #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEF_PERIOD = 2,
  parameter int unsigned DEF_HIGH   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] high_in,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   act_p_q, act_p_d;
  logic [WIDTH-1:0]   act_h_q, act_h_d;
  logic [WIDTH-1:0]   pend_p_q, pend_p_d;
  logic [WIDTH-1:0]   pend_h_q, pend_h_d;
  logic               pend_v_q, pend_v_d;
  logic               clk_out_q, clk_out_d;
  logic               tick_q, tick_d;
  logic               running_q, running_d;
  logic               cfg_err_q, cfg_err_d;

  logic               wrap;
  logic               adopt;
  logic               load_ok;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    act_p_d   = act_p_q;
    act_h_d   = act_h_q;
    pend_p_d  = pend_p_q;
    pend_h_d  = pend_h_q;
    pend_v_d  = pend_v_q;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
    running_d = 1'b0;
    cfg_err_d = 1'b0;

    // act_p is always >= 2, so act_p - 1 never underflows.
    wrap    = (state_q != ST_IDLE) && (count_q == act_p_q - WIDTH'(1));
    load_ok = load && (period_in >= WIDTH'(2));

    // Pending config is promoted only while idle or on the wrap edge,
    // which is what keeps clk_out free of runt pulses.
    adopt = pend_v_q && ((state_q == ST_IDLE) || wrap);
    if (adopt) begin
      act_p_d  = pend_p_q;
      act_h_d  = pend_h_q;
      pend_v_d = 1'b0;
    end

    // A load on the same edge as a promotion lands in the pending slot
    // after the old pending value has moved to active.
    if (load_ok) begin
      pend_p_d = period_in;
      pend_h_d = (high_in > period_in) ? period_in : high_in;
      pend_v_d = 1'b1;
    end
    cfg_err_d = load && !load_ok;

    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        count_d = wrap ? '0 : count_q + WIDTH'(1);
        if (enable) begin
          state_d = ST_RUN;
        end else if (wrap) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    // Outputs reflect the new count and the config in force after this edge.
    if (state_d != ST_IDLE) begin
      running_d = 1'b1;
      clk_out_d = (count_d < act_h_d);
      tick_d    = (count_d == '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      act_p_q   <= WIDTH'(DEF_PERIOD);
      act_h_q   <= WIDTH'(DEF_HIGH);
      pend_p_q  <= '0;
      pend_h_q  <= '0;
      pend_v_q  <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      act_p_q   <= act_p_d;
      act_h_q   <= act_h_d;
      pend_p_q  <= pend_p_d;
      pend_h_q  <= pend_h_d;
      pend_v_q  <= pend_v_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign running = running_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_pwm.sv
// Bench for clk_div_pwm: directed scenarios plus random enable/load traffic against a period-position model.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 time unit after the edge.
// The model tracks "position within the current period" and the active/pending configs.
module tb_clk_div_pwm;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         load;
  logic [W-1:0] period_in;
  logic [W-1:0] high_in;
  logic         clk_out;
  logic         tick;
  logic         running;
  logic         cfg_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_p, m_h, m_pp, m_ph, m_pos;
  bit m_pv, m_on;
  bit e_clk, e_tick, e_run, e_err;

  always #5 clock = ~clock;

  clk_div_pwm #(.WIDTH(W), .DEF_PERIOD(2), .DEF_HIGH(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .period_in (period_in),
    .high_in   (high_in),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running),
    .cfg_err   (cfg_err)
  );

  function automatic void model_reset();
    m_p = 2; m_h = 1; m_pp = 0; m_ph = 0; m_pos = 0;
    m_pv = 0; m_on = 0;
    e_clk = 0; e_tick = 0; e_run = 0; e_err = 0;
  endfunction

  // One clock edge of the reference, using the inputs as they stand at the edge.
  function automatic void model_step();
    bit wrap;
    int lp, lh;
    lp   = int'(period_in);
    lh   = int'(high_in);
    wrap = m_on && (m_pos == m_p - 1);
    if ((!m_on || wrap) && m_pv) begin
      m_p  = m_pp;
      m_h  = m_ph;
      m_pv = 0;
    end
    if (!m_on) begin
      m_pos = 0;
      m_on  = enable;
    end else begin
      m_pos = wrap ? 0 : m_pos + 1;
      if (wrap && !enable) m_on = 0;
    end
    e_err = load && (lp < 2);
    if (load && lp >= 2) begin
      m_pp = lp;
      m_ph = (lh < lp) ? lh : lp;
      m_pv = 1;
    end
    e_run  = m_on;
    e_clk  = m_on && (m_pos < m_h);
    e_tick = m_on && (m_pos == 0);
  endfunction

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_load(input int p, input int h);
    load      = 1'b1;
    period_in = W'(p);
    high_in   = W'(h);
    step();
    load = 1'b0;
    if ({clk_out, tick, running, cfg_err} !== {e_clk, e_tick, e_run, e_err}) begin
      bad++;
      $display("FAIL load_cycle p=%0d h=%0d: got %b want %b", p, h,
               {clk_out, tick, running, cfg_err}, {e_clk, e_tick, e_run, e_err});
    end
    total++;
  endtask

  task automatic go_idle();
    enable = 1'b0;
    for (int i = 0; i < 40 && m_on; i++) begin
      step();
      if ({clk_out, tick, running, cfg_err} !== {e_clk, e_tick, e_run, e_err}) begin
        bad++;
        $display("FAIL go_idle cyc%0d: got %b want %b", i,
                 {clk_out, tick, running, cfg_err}, {e_clk, e_tick, e_run, e_err});
      end
      total++;
    end
    if (running !== 1'b0) begin
      bad++;
      $display("FAIL go_idle_timeout: running=%b want 0", running);
    end
    total++;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; load = 1'b0; period_in = '0; high_in = '0;
    model_reset();
    #12;
    if ({clk_out, tick, running, cfg_err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0000", {clk_out, tick, running, cfg_err});
    end
    total++;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if ({clk_out, tick, running, cfg_err} !== {e_clk, e_tick, e_run, e_err}) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: got %b want %b", i,
                 {clk_out, tick, running, cfg_err}, {e_clk, e_tick, e_run, e_err});
      end
      total++;
    end
  endtask

  task automatic test_defaults();
    logic [7:0] pat;
    int ticks;
    pat = '0; ticks = 0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      pat   = {pat[6:0], clk_out};
      ticks += int'(tick);
      if ({clk_out, tick, running, cfg_err} !== {e_clk, e_tick, e_run, e_err}) begin
        bad++;
        $display("FAIL defaults cyc%0d: got %b want %b", i,
                 {clk_out, tick, running, cfg_err}, {e_clk, e_tick, e_run, e_err});
      end
      total++;
    end
    if (pat !== 8'b10101010) begin
      bad++;
      $display("FAIL defaults_pattern: got %b want 10101010", pat);
    end
    total++;
    if (ticks != 4) begin
      bad++;
      $display("FAIL defaults_ticks: got %0d want 4", ticks);
    end
    total++;
    go_idle();
  endtask

  task automatic test_duty();
    logic [9:0] pat;
    int highs, ticks;
    pat = '0; highs = 0; ticks = 0;
    do_load(10, 3);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i < 10) pat = {pat[8:0], clk_out};
      highs += int'(clk_out);
      ticks += int'(tick);
      if ({clk_out, tick, running, cfg_err} !== {e_clk, e_tick, e_run, e_err}) begin
        bad++;
        $display("FAIL duty cyc%0d: got %b want %b", i,
                 {clk_out, tick, running, cfg_err}, {e_clk, e_tick, e_run, e_err});
      end
      total++;
    end
    if (pat !== 10'b1110000000) begin
      bad++;
      $display("FAIL duty_pattern: got %b want 1110000000", pat);
    end
    total++;
    if (highs != 6 || ticks != 2) begin
      bad++;
      $display("FAIL duty_counts: got highs=%0d ticks=%0d want highs=6 ticks=2", highs, ticks);
    end
    total++;
    go_idle();
  endtask

  task automatic test_glitch_free();
    logic [13:0] pat;
    pat = '0;
    do_load(4, 2);
    enable = 1'b1;
    step();
    step();
    load = 1'b1; period_in = 8'd6; high_in = 8'd1;
    for (int i = 0; i < 14; i++) begin
      step();
      load = 1'b0;
      pat  = {pat[12:0], clk_out};
      if ({clk_out, tick, running, cfg_err} !== {e_clk, e_tick, e_run, e_err}) begin
        bad++;
        $display("FAIL glitch cyc%0d: got %b want %b", i,
                 {clk_out, tick, running, cfg_err}, {e_clk, e_tick, e_run, e_err});
      end
      total++;
    end
    if (pat !== 14'b00100000100000) begin
      bad++;
      $display("FAIL glitch_pattern: got %b want 00100000100000", pat);
    end
    total++;
    go_idle();
  endtask

  task automatic test_invalid_clamp();
    logic [5:0] pat;
    int highs, ticks;
    pat = '0; highs = 0; ticks = 0;
    do_load(1, 1);
    if (cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL cfg_err_pulse: got %b want 1", cfg_err);
    end
    total++;
    step();
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL cfg_err_one_cycle: got %b want 0", cfg_err);
    end
    total++;
    // Previous config (P=6, H=1) must still be in force.
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      pat = {pat[4:0], clk_out};
    end
    if (pat !== 6'b100000) begin
      bad++;
      $display("FAIL invalid_keeps_cfg: got %b want 100000", pat);
    end
    total++;
    go_idle();
    do_load(5, 9);
    enable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      highs += int'(clk_out);
      ticks += int'(tick);
      if ({clk_out, tick, running, cfg_err} !== {e_clk, e_tick, e_run, e_err}) begin
        bad++;
        $display("FAIL clamp cyc%0d: got %b want %b", i,
                 {clk_out, tick, running, cfg_err}, {e_clk, e_tick, e_run, e_err});
      end
      total++;
    end
    if (highs != 15 || ticks != 3) begin
      bad++;
      $display("FAIL clamp_counts: got highs=%0d ticks=%0d want highs=15 ticks=3", highs, ticks);
    end
    total++;
    go_idle();
  endtask

  task automatic test_drain();
    int run_cycles;
    run_cycles = 0;
    do_load(8, 4);
    enable = 1'b1;
    step();
    step();
    step();
    // count is now 2; the drop is sampled on the next edge
    enable = 1'b0;
    for (int i = 0; i < 20 && running === 1'b1; i++) begin
      step();
      if (running === 1'b1) run_cycles++;
      if ({clk_out, tick, running, cfg_err} !== {e_clk, e_tick, e_run, e_err}) begin
        bad++;
        $display("FAIL drain cyc%0d: got %b want %b", i,
                 {clk_out, tick, running, cfg_err}, {e_clk, e_tick, e_run, e_err});
      end
      total++;
    end
    if (run_cycles != 5 || clk_out !== 1'b0) begin
      bad++;
      $display("FAIL drain_length: got cycles=%0d clk_out=%b want cycles=5 clk_out=0",
               run_cycles, clk_out);
    end
    total++;
  endtask

  task automatic test_drain_resume();
    logic [15:0] pat;
    int runs;
    pat = '0; runs = 0;
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) enable = 1'b0;
      if (i == 5) enable = 1'b1;
      step();
      pat  = {pat[14:0], clk_out};
      runs += int'(running);
      if ({clk_out, tick, running, cfg_err} !== {e_clk, e_tick, e_run, e_err}) begin
        bad++;
        $display("FAIL resume cyc%0d: got %b want %b", i,
                 {clk_out, tick, running, cfg_err}, {e_clk, e_tick, e_run, e_err});
      end
      total++;
    end
    if (pat !== 16'b1111000011110000 || runs != 16) begin
      bad++;
      $display("FAIL resume_pattern: got %b runs=%0d want 1111000011110000 runs=16", pat, runs);
    end
    total++;
    go_idle();
  endtask

  task automatic test_async_reset();
    int i;
    do_load(4, 2);
    enable = 1'b1;
    i = 0;
    step();
    while (clk_out !== 1'b1 && i < 10) begin
      step();
      i++;
    end
    if (clk_out !== 1'b1) begin
      bad++;
      $display("FAIL async_setup: clk_out=%b want 1", clk_out);
    end
    total++;
    #2;
    reset = 1'b1;
    #1;
    if ({clk_out, tick, running, cfg_err} !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset: got %b want 0000", {clk_out, tick, running, cfg_err});
    end
    total++;
    model_reset();
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    step();
    enable = 1'b1;
    step();
    if ({clk_out, tick, running} !== 3'b111) begin
      bad++;
      $display("FAIL async_restart_defaults: got %b want 111", {clk_out, tick, running});
    end
    total++;
    go_idle();
  endtask

  task automatic test_random();
    enable = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 9) == 0) begin
        load      = 1'b1;
        period_in = W'($urandom_range(0, 12));
        high_in   = W'($urandom_range(0, 14));
      end else begin
        load = 1'b0;
      end
      step();
      if ({clk_out, tick, running, cfg_err} !== {e_clk, e_tick, e_run, e_err}) begin
        bad++;
        $display("FAIL random cyc%0d: got %b want %b", i,
                 {clk_out, tick, running, cfg_err}, {e_clk, e_tick, e_run, e_err});
      end
      total++;
    end
    load = 1'b0;
    go_idle();
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_duty();
    test_glitch_free();
    test_invalid_clamp();
    test_drain();
    test_drain_resume();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_pwm.md
# clk_div_pwm

Programmable synthesizable clock divider with duty-cycle control. It takes the single system clock and produces a divided output `clk_out` with period P and high time H, both counted in input clock cycles. The configuration is double-buffered and only changes on period boundaries, so the output never glitches. It sits directly downstream of the clock-generation stage and supplies derived clocks and enables, for example 1 MHz at 30 % duty from a 10 MHz reference, to the blocks that follow.

## Interface
- `WIDTH`, 8: width of the period, high-time and counter fields.
- `DEF_PERIOD`, 2: active period P after reset; must be ≥ 2.
- `DEF_HIGH`, 1: active high time H after reset; must be ≤ `DEF_PERIOD`.

- `clock` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `enable` input 1: run request, level-sensitive.
- `load` input 1: single-cycle strobe that captures `period_in` and `high_in`.
- `period_in` input WIDTH: requested period P, in cycles.
- `high_in` input WIDTH: requested high time H, in cycles.
- `clk_out` output 1: divided clock, registered.
- `tick` output 1: one-cycle pulse on the first cycle of every output period.
- `running` output 1: high when the state is not IDLE.
- `cfg_err` output 1: one-cycle pulse when a `load` is rejected.

## Operation
- Registers:
  - active config `act_p` / `act_h`.
  - pending config `pend_p` / `pend_h` plus flag `pend_v`.
  - counter `count`.
  - state: IDLE, RUN or DRAIN.
- Reset values:
  - `clk_out`=0, `tick`=0, `running`=0, `cfg_err`=0.
  - `count`=0, state=IDLE.
  - `act_p`=`DEF_PERIOD`, `act_h`=`DEF_HIGH`, `pend_v`=0.
- Load handling:
  - `load` with `period_in` < 2: `cfg_err`=1 for the next cycle; all config registers are unchanged.
  - Otherwise: `pend_p`=`period_in`, `pend_h`=min(`high_in`, `period_in`), `pend_v`=1.
  - A newer load overwrites an older pending one.
- IDLE:
  - `clk_out`=0, `count`=0.
  - If `pend_v`=1, the pending config is copied to active on the next edge and `pend_v` clears.
  - `enable`=1 sampled → RUN.
- RUN / DRAIN counting, every edge:
  - `count` = (`count` == `act_p`-1) ? 0 : `count`+1.
  - `clk_out` = (new `count` < `act_h`).
  - `tick` = (new `count` == 0).
- Period boundary (the wrap edge, `count` == `act_p`-1):
  - If `pend_v`=1, the new period uses the pending config (copy, clear `pend_v`).
  - A `load` sampled on the wrap edge itself becomes pending and applies at the following boundary.
- RUN → DRAIN: `enable`=0 sampled on a non-wrap edge. DRAIN finishes the current period.
- RUN → IDLE: `enable`=0 sampled on a wrap edge.
- DRAIN → IDLE: on the wrap edge.
  - `clk_out`=0, `count`=0, no `tick`.
- DRAIN → RUN: `enable`=1 sampled. Counting continues uninterrupted.
- H = 0 gives `clk_out` constantly 0 while running; H = P gives constantly 1. `tick` pulses in both cases.
- All arithmetic is unsigned WIDTH-bit. The counter never exceeds `act_p`-1.

## Timing
- Start latency: `enable` sampled high at edge k in IDLE → at edge k:
  - state=RUN, `count`=0, `tick`=1.
  - `clk_out`=(`act_h` > 0).
  - Any pending config is applied at that same edge, ahead of the start.
- Steady state: `clk_out` is high for exactly `act_h` cycles, then low for `act_p`-`act_h` cycles.
- `tick` coincides with the first high cycle of each period.
- `running` is registered with the state: it is 1 from edge k and falls on the edge that enters IDLE.
- `cfg_err` appears the cycle after the offending `load`.
- Reset mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset defaults: `enable`=1 after reset → `clk_out` pattern 1,0 repeating; `tick` every 2 cycles.
- Duty-cycle case: load P=10, H=3 in IDLE, then enable → `clk_out` 3 cycles high, 7 low; `tick` every 10 cycles. With a 10 MHz clock this gives 1 MHz at 30 % duty.
- Glitch-free update: running P=4, H=2 (pattern 1100); load P=6, H=1 mid-period → current period completes as 1100, then the pattern becomes 100000.
- Invalid loads and clamp: load P=1 → `cfg_err` pulse, config unchanged. Load P=5, H=9 → clamped to H=5, `clk_out` constantly 1, `tick` every 5 cycles.
- Drain: P=8, H=4; drop `enable` at `count`=2 → 5 more cycles, then IDLE with `clk_out`=0. Repeat, but re-raise `enable` during DRAIN → no interruption in the pattern.
- Async reset: assert `reset` between edges while `clk_out`=1 → `clk_out`, `tick` and `running` go to 0 immediately.
